// File: rtl/cim_drain.sv
// Drain engine for a CiM cell group: snapshots N_GROUP accumulator words, streams them
// out in index order over valid/ready, pulses a clear back to the group and reports the sum.
module cim_drain #(
  parameter int N_GROUP    = 12,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_WIDTH = (N_GROUP > 1) ? $clog2(N_GROUP) : 1,
  localparam int SUM_WIDTH = DATA_WIDTH + $clog2(N_GROUP) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic [N_GROUP-1:0][DATA_WIDTH-1:0] acc_i,
  output logic                               busy_o,
  output logic                               clear_o,
  output logic                               m_valid_o,
  input  logic                               m_ready_i,
  output logic [DATA_WIDTH-1:0]              m_data_o,
  output logic [IDX_WIDTH-1:0]               m_idx_o,
  output logic                               m_last_o,
  output logic                               done_o,
  output logic [SUM_WIDTH-1:0]               sum_o
);

  // Output handshake: a beat transfers on a cycle where m_valid_o && m_ready_i.
  // Once raised, m_valid_o and the beat payload hold until that transfer happens.

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_GROUP - 1);

  state_t                             state;
  logic [N_GROUP-1:0][DATA_WIDTH-1:0] snap;
  logic [IDX_WIDTH-1:0]               idx;
  logic [SUM_WIDTH-1:0]               run_sum;

  logic                               streaming;
  logic                               at_last;
  logic [DATA_WIDTH-1:0]              cur_word;
  logic [SUM_WIDTH-1:0]               cur_word_ext;

  assign streaming    = (state == STREAM);
  assign at_last      = (idx == LAST_IDX);
  assign cur_word     = snap[idx];
  assign cur_word_ext = SUM_WIDTH'(cur_word);

  // busy_o is the state itself, which also serves as the FSM debug view.
  assign busy_o    = streaming;
  assign m_valid_o = streaming;
  assign m_data_o  = streaming ? cur_word : '0;
  assign m_idx_o   = streaming ? idx : '0;
  assign m_last_o  = streaming && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      snap    <= '0;
      idx     <= '0;
      run_sum <= '0;
      sum_o   <= '0;
      done_o  <= 1'b0;
      clear_o <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      clear_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            snap    <= acc_i;
            idx     <= '0;
            run_sum <= '0;
            clear_o <= 1'b1;
            state   <= STREAM;
          end
        end
        STREAM: begin
          // start_i is deliberately not looked at here, even on the final beat.
          if (m_ready_i) begin
            if (at_last) begin
              sum_o  <= run_sum + cur_word_ext;
              done_o <= 1'b1;
              state  <= IDLE;
            end else begin
              idx     <= idx + 1'b1;
              run_sum <= run_sum + cur_word_ext;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (m_valid_o && !m_ready_i) |=> (m_valid_o && $stable(m_data_o) && $stable(m_idx_o) && $stable(m_last_o)));

  a_clear_in_stream: assert property (@(posedge clk) disable iff (rst)
    clear_o |-> busy_o);

  a_done_idle: assert property (@(posedge clk) disable iff (rst)
    done_o |-> !busy_o);

endmodule

// File: tb/tb_cim_drain.sv
// Randomized bench for cim_drain: a drain-level reference model predicts beats and
// per-cycle status, and a monitor compares the DUT against it on the falling edge.
module tb_cim_drain;

  localparam int N  = 12;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int SW = DW + $clog2(N) + 1;

  // clock / reset / DUT signals
  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic                   m_ready = 1'b0;
  logic [N-1:0][DW-1:0]   acc = '0;
  logic                   busy, clear, m_valid, m_last, done;
  logic [DW-1:0]          m_data;
  logic [IW-1:0]          m_idx;
  logic [SW-1:0]          sum;

  always #5 clk = ~clk;

  cim_drain #(.N_GROUP(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .acc_i     (acc),
    .busy_o    (busy),
    .clear_o   (clear),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .m_idx_o   (m_idx),
    .m_last_o  (m_last),
    .done_o    (done),
    .sum_o     (sum)
  );

  int cmp_count  = 0;
  int fail_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a drain is "N beats of the captured words, then done with their sum"
  logic [DW+IW:0] exp_q[$];
  bit             mdl_on  = 1'b0;
  bit             m_busy  = 1'b0;
  int             left    = 0;
  bit             e_clear = 1'b0;
  bit             e_done  = 1'b0;
  logic [SW-1:0]  e_sum   = '0;
  logic [SW-1:0]  pend_sum = '0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_on  = 1'b1;
      m_busy  = 1'b0;
      left    = 0;
      e_clear = 1'b0;
      e_done  = 1'b0;
      e_sum   = '0;
      exp_q.delete();
    end else begin
      e_clear = 1'b0;
      e_done  = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy   = 1'b1;
          left     = N;
          e_clear  = 1'b1;
          pend_sum = '0;
          for (int k = 0; k < N; k++) begin
            pend_sum = pend_sum + SW'(acc[k]);
            exp_q.push_back({acc[k], IW'(k), (k == N - 1)});
          end
        end
      end else if (m_ready) begin
        left = left - 1;
        if (left == 0) begin
          m_busy = 1'b0;
          e_done = 1'b1;
          e_sum  = pend_sum;
        end
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [DW+IW:0] front;
    if (mdl_on) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("valid", 64'(m_valid), 64'(m_busy));
      check("clear", 64'(clear), 64'(e_clear));
      check("done", 64'(done), 64'(e_done));
      check("sum", 64'(sum), 64'(e_sum));
      if (m_busy) begin
        if (exp_q.size() == 0) begin
          cmp_count++;
          fail_count++;
          $display("FAIL beat_queue: DUT beat idx %0d with no expected beat", m_idx);
        end else begin
          front = exp_q[0];
          check("beat_data", 64'(m_data), 64'(front[DW+IW:IW+1]));
          check("beat_idx", 64'(m_idx), 64'(front[IW:1]));
          check("beat_last", 64'(m_last), 64'(front[0]));
          if (m_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("mask_data", 64'(m_data), 64'd0);
        check("mask_idx", 64'(m_idx), 64'd0);
        check("mask_last", 64'(m_last), 64'd0);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rand_acc();
    for (int k = 0; k < N; k++) acc[k] = $urandom;
  endtask

  initial begin
    // reset state and idle hold
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    // basic drain: words 1..12
    for (int k = 0; k < N; k++) acc[k] = DW'(k + 1);
    m_ready = 1'b1;
    pulse_start();
    repeat (14) tick();
    check("basic_sum_78", 64'(sum), 64'd78);

    // backpressure 1,0,0 pattern
    rand_acc();
    pulse_start();
    for (int i = 0; i < 45; i++) begin
      m_ready = (i % 3 == 0);
      tick();
    end
    m_ready = 1'b1;
    repeat (3) tick();

    // snapshot isolation: input changes right after capture
    rand_acc();
    pulse_start();
    acc = '1;
    repeat (15) tick();

    // all-ones capture, sum must not wrap
    acc = '1;
    pulse_start();
    repeat (15) tick();
    check("ones_sum", 64'(sum), 64'h0000_000B_FFFF_FFF4);

    // start held high: back-to-back drains
    rand_acc();
    start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      acc[$urandom_range(0, N - 1)] = $urandom;
    end
    start = 1'b0;
    repeat (15) tick();

    // reset after beat idx 4 is accepted
    rand_acc();
    m_ready = 1'b1;
    pulse_start();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_sum", 64'(sum), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    tick();
    rand_acc();
    pulse_start();
    repeat (15) tick();

    // random ready / random start traffic
    for (int r = 0; r < 8; r++) begin
      rand_acc();
      pulse_start();
      for (int i = 0; i < 40; i++) begin
        m_ready = 1'($urandom_range(0, 1));
        start   = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) acc[$urandom_range(0, N - 1)] = $urandom;
        tick();
      end
      start   = 1'b0;
      m_ready = 1'b1;
      repeat (15) tick();
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end

endmodule

// File: doc/cim_drain.md
# cim_drain

Readout engine for a CiM cell group. It snapshots the group's N_GROUP parallel accumulator words on request and streams them out one word per beat over a valid/ready interface, in index order. It also pulses a clear request back to the group and reports the sum of the drained words. It sits between the `cim_cell_group` data outputs and the downstream consumer (host DMA or a reduction stage).

## Interface
- `N_GROUP`, 12, number of accumulator cells read per drain (≥1)
- `DATA_WIDTH`, 32, width of each accumulator word
- `IDX_WIDTH` (local), `max(1, $clog2(N_GROUP))`, width of beat index
- `SUM_WIDTH` (local), `DATA_WIDTH + $clog2(N_GROUP) + 1`, width of the sum result
- Reset `rst` is synchronous and active-high; the clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start_i`  in  1  drain request; sampled only in IDLE
- `acc_i`  in  N_GROUP×DATA_WIDTH  accumulator words from the cell group, packed array
- `busy_o`  out  1  high while a drain is in progress
- `clear_o`  out  1  one-cycle request to zero the source cells
- `m_valid_o`  out  1  output beat valid
- `m_ready_i`  in  1  consumer ready
- `m_data_o`  out  DATA_WIDTH  beat data
- `m_idx_o`  out  IDX_WIDTH  cell index of the current beat
- `m_last_o`  out  1  current beat is index N_GROUP-1
- `done_o`  out  1  one-cycle pulse after the final beat is accepted
- `sum_o`  out  SUM_WIDTH  zero-extended sum of all words in the last completed drain

## Operation
- FSM has two states: IDLE and STREAM.
- **IDLE, start_i high:**
  - Register all of `acc_i` into the snapshot.
  - Zero the index and the running sum.
  - Go to STREAM.
- **IDLE, start_i low:** stay in IDLE.
- **STREAM:**
  - `m_valid_o` is 1.
  - `m_data_o` = snapshot[idx]; `m_idx_o` = idx; `m_last_o` = (idx == N_GROUP-1).
- **Handshake** is `m_valid_o && m_ready_i`. On each handshake:
  - running sum += zero-extended `m_data_o`;
  - idx increments.
- **Final-beat handshake:**
  - `sum_o` is loaded with the complete sum, including the last word.
  - `done_o` is registered high for the next cycle.
  - FSM returns to IDLE.
- **Stall rules:**
  - `m_valid_o` never drops before its handshake.
  - `m_data_o`, `m_idx_o` and `m_last_o` stay stable while `m_ready_i` is low.
- **Snapshot isolation:** changes on `acc_i` after capture have no effect on the streamed data.
- **`clear_o`:**
  - High exactly in the first STREAM cycle, regardless of `m_ready_i`.
  - Because the snapshot is already held, the group may be zeroed and resume accumulating immediately.
- **`busy_o`:** equals (state == STREAM).
- **`start_i` in STREAM:** ignored, including in the final-beat handshake cycle.
- **Output masking:** when `m_valid_o` is 0, `m_data_o`, `m_idx_o` and `m_last_o` are 0.
- **Sum width:** the running sum cannot overflow at `SUM_WIDTH`; no saturation is applied.
- **`N_GROUP` = 1:** the single beat has `m_last_o` = 1.

## Timing
- **Reset values:** all outputs are 0, including `sum_o`. The snapshot, idx and running sum are cleared. State is IDLE.
- **Reset mid-drain:** abort the drain. The next cycle is IDLE with all outputs 0, no `done_o` and no `clear_o`.
- **Start latency:** `start_i` sampled high at edge T (IDLE) gives:
  - `m_valid_o`, `busy_o` and `clear_o` high in cycle T+1;
  - `clear_o` low from T+2.
- **Throughput:** with `m_ready_i` held high, beats idx 0..N_GROUP-1 occupy cycles T+1..T+N_GROUP.
  - `done_o` and the new `sum_o` appear in T+N_GROUP+1.
  - `busy_o` is low from T+N_GROUP+1.
- **Stalls:** each cycle with `m_ready_i` low adds one cycle to the drain.
- **Back-to-back drains:**
  - A `start_i` sampled in the `done_o` cycle is accepted.
  - The minimum start-to-start spacing is N_GROUP+1 cycles.
- **`sum_o` hold:** holds its value until the next final-beat handshake; it is not cleared by `start_i`.

## Test plan
- **Reset state:**
  - Stimulus: hold rst 2 cycles.
  - Required: all outputs 0; `start_i` low keeps IDLE.
- **Basic drain:**
  - Stimulus: N_GROUP=12, acc_i[k]=k+1, `m_ready_i`=1, `start_i` pulse at T.
  - Required: beats with data 1..12 and idx 0..11 in T+1..T+12; `m_last_o` only on idx 11; `clear_o` only at T+1; `done_o` at T+13; `sum_o`=78.
- **Backpressure:**
  - Stimulus: `m_ready_i` toggles 1,0,0,1,...
  - Required: data and idx stable through stalls; no beat lost or duplicated; `done_o` one cycle after the last accepted beat.
- **Snapshot isolation and overflow:**
  - Stimulus: after capture, drive `acc_i` to all 0xFFFFFFFF.
  - Required: streamed data equals the captured values.
  - Stimulus: separately, capture all words = 0xFFFFFFFF.
  - Required: `sum_o` = 12×0xFFFFFFFF = 0xB_FFFF_FFF4, with no wrap.
- **Start while busy, then back-to-back:**
  - Stimulus: `start_i` held high continuously.
  - Required: drains start every 13 cycles; the start in the final-beat cycle is ignored; the start in the `done_o` cycle is accepted.
- **Reset mid-drain:**
  - Stimulus: rst asserted after beat idx 4 is accepted.
  - Required: next cycle all outputs 0, no `done_o`, `sum_o`=0; a new start streams from idx 0.
